// File: rtl/vector_multiply_pipe.sv
// Pipelined multiply / multiply-accumulate unit for one rv32v vector lane (SEW8/16/32).
// Optional fixed-point vsmul with rnu rounding and saturation is enabled by defining VMUL_SMUL_EN.
//
// Handshake: the whole pipeline advances in lock-step when advance = !out_valid | out_ready.
// An op enters on in_valid & in_ready (in_ready = advance & !flush); a result leaves on
// out_valid & out_ready. While out_valid & !out_ready every stage and all out_* hold.
module vector_multiply_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  vs1,
  input  logic [XLEN-1:0]  vs2,
  input  logic [XLEN-1:0]  vs3,
  input  logic [1:0]       sew,
  input  logic [1:0]       sign_mode,
  input  logic             high_sel,
  input  logic             widen,
  input  logic             macc,
  input  logic             macc_neg,
  input  logic             smul,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_exc,
  output logic             out_vxsat,
  output logic             busy
);

  localparam int PW = 2 * XLEN;
  localparam logic [PW-1:0] ONES = '1;
  localparam logic [PW-1:0] ONE  = {{(PW-1){1'b0}}, 1'b1};

  function automatic logic [PW-1:0] low_mask(input int n);
    return ONES >> (PW - n);
  endfunction

  function automatic logic [PW-1:0] ext_op(input logic [XLEN-1:0] v, input logic [1:0] s,
                                           input logic sgn);
    case (s)
      2'b00:   return sgn ? {{(PW-8){v[7]}}, v[7:0]}    : {{(PW-8){1'b0}}, v[7:0]};
      2'b01:   return sgn ? {{(PW-16){v[15]}}, v[15:0]} : {{(PW-16){1'b0}}, v[15:0]};
      2'b10:   return sgn ? {{(PW-32){v[31]}}, v[31:0]} : {{(PW-32){1'b0}}, v[31:0]};
      default: return '0;
    endcase
  endfunction

  logic            advance, in_fire, illegal, sat;
  int              sw, rw;
  logic [PW-1:0]   a_ext, b_ext, prod, sel, vs3_m, rmask, acc;
  logic [XLEN-1:0] res;
  logic [PW-XLEN-1:0] acc_unused;

`ifndef VMUL_SMUL_EN
  logic smul_unused;
  assign smul_unused = smul;
`endif

  always_comb begin
    sw      = (sew == 2'b00) ? 8 : (sew == 2'b01) ? 16 : 32;
    rw      = widen ? 2 * sw : sw;
    a_ext   = ext_op(vs2, sew, (sign_mode == 2'b01) || (sign_mode == 2'b10));
    b_ext   = ext_op(vs1, sew, (sign_mode == 2'b01));
    prod    = a_ext * b_ext;
    rmask   = low_mask(rw);
    sel     = (high_sel && !widen) ? (prod >> sw) : prod;
    vs3_m   = {{(PW-XLEN){1'b0}}, vs3} & rmask;
    acc     = macc ? (macc_neg ? (vs3_m - sel) : (sel + vs3_m)) : sel;
    acc     = acc & rmask;
    illegal = (sew == 2'b11) || (sign_mode == 2'b11) || (widen && (sew == 2'b10)) ||
              (widen && high_sel);
    sat     = 1'b0;
`ifdef VMUL_SMUL_EN
    if (smul) begin
      illegal = illegal || widen || macc || (sign_mode != 2'b01);
      // Only (-2^(SEW-1))^2 overflows the rounded SEW-bit result.
      sat     = (a_ext == b_ext) && (a_ext == (ONES << (sw - 1)));
      acc     = sat ? low_mask(sw - 1)
                    : (($signed(prod + (ONE << (sw - 2)))) >>> (sw - 1)) & low_mask(sw);
    end
`endif
    if (illegal) begin
      acc = '0;
      sat = 1'b0;
    end
    res = acc[XLEN-1:0];
  end

  assign acc_unused = acc[PW-1:XLEN];

  // Stage registers; index STAGES-1 drives the outputs.
  logic [STAGES-1:0] valid_q, valid_d, exc_q, exc_d, vx_q, vx_d;
  logic [XLEN-1:0]   data_q [STAGES];
  logic [XLEN-1:0]   data_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];

  assign advance  = !valid_q[STAGES-1] || out_ready;
  assign in_ready = advance && !flush;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    exc_d   = exc_q;
    vx_d    = vx_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (flush) begin
      valid_d = '0;
    end else if (advance) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
        exc_d[i]   = exc_q[i-1];
        vx_d[i]    = vx_q[i-1];
        data_d[i]  = data_q[i-1];
        tag_d[i]   = tag_q[i-1];
      end
      valid_d[0] = in_fire;
      exc_d[0]   = in_fire && illegal;
      vx_d[0]    = in_fire && sat;
      data_d[0]  = in_fire ? res : '0;
      tag_d[0]   = in_fire ? in_tag : '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      exc_q   <= '0;
      vx_q    <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      exc_q   <= exc_d;
      vx_q    <= vx_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  // Without VMUL_SMUL_EN sat is constant 0, so the vxsat chain reduces to a tie-off.
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_exc   = exc_q[STAGES-1];
  assign out_vxsat = vx_q[STAGES-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_vector_multiply_pipe.sv
// Self-checking bench for vector_multiply_pipe: directed vectors, handshake/stall, flush, reset
// and randomized traffic against an arithmetic reference model.
module tb_vector_multiply_pipe;
  localparam int XLEN   = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 5;
  localparam int W      = 2 + TAG_W + XLEN;

  logic             CLK = 1'b0;
  logic             nRST, flush, in_valid, in_ready;
  logic [XLEN-1:0]  vs1, vs2, vs3;
  logic [1:0]       sew, sign_mode;
  logic             high_sel, widen, macc, macc_neg, smul;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_exc, out_vxsat, busy;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic             hold_pending = 1'b0;
  logic [XLEN-1:0]  hold_data;
  logic [TAG_W-1:0] hold_tag;

  vector_multiply_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .vs1(vs1), .vs2(vs2), .vs3(vs3), .sew(sew), .sign_mode(sign_mode),
    .high_sel(high_sel), .widen(widen), .macc(macc), .macc_neg(macc_neg), .smul(smul),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_exc(out_exc), .out_vxsat(out_vxsat), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [31:0] v1, input logic [31:0] v2,
      input logic [31:0] v3, input logic [1:0] s, input logic [1:0] sm, input logic hs,
      input logic wd, input logic mc, input logic mn, input logic sml,
      input logic [TAG_W-1:0] tg);
    int     n;
    longint a, b, p, r, m, mr;
    logic   exc, vx;
    logic [31:0] r32;
    exc = (s == 2'd3) || (sm == 2'd3) || (wd && s == 2'd2) || (wd && hs);
`ifdef VMUL_SMUL_EN
    if (sml && (wd || mc || sm != 2'd1)) exc = 1'b1;
`endif
    if (exc) return {1'b0, 1'b1, tg, 32'h0};
    n = 8 << s;
    m = (longint'(1) << n) - 1;
    a = longint'({32'h0, v2}) & m;
    b = longint'({32'h0, v1}) & m;
    if (sm != 2'd0 && a >= (longint'(1) << (n - 1))) a = a - (longint'(1) << n);
    if (sm == 2'd1 && b >= (longint'(1) << (n - 1))) b = b - (longint'(1) << n);
    p  = a * b;
    vx = 1'b0;
`ifdef VMUL_SMUL_EN
    if (sml) begin
      if (a == -(longint'(1) << (n - 1)) && b == a) begin
        r  = (longint'(1) << (n - 1)) - 1;
        vx = 1'b1;
      end else begin
        r = (p + (longint'(1) << (n - 2))) >>> (n - 1);
      end
      r   = r & m;
      r32 = r[31:0];
      return {vx, 1'b0, tg, r32};
    end
`endif
    mr = wd ? ((longint'(1) << (2 * n)) - 1) : m;
    r  = hs ? (p >>> n) : p;
    if (mc) r = mn ? (longint'({32'h0, v3}) - r) : (r + longint'({32'h0, v3}));
    r   = r & mr;
    r32 = r[31:0];
    return {vx, 1'b0, tg, r32};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [1:0] s, input logic [1:0] sm, input logic hs,
      input logic wd, input logic mc, input logic mn, input logic sml,
      input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3,
      input logic [TAG_W-1:0] tg);
    in_valid = 1'b1; sew = s; sign_mode = sm; high_sel = hs; widen = wd; macc = mc;
    macc_neg = mn; smul = sml; vs1 = v1; vs2 = v2; vs3 = v3; in_tag = tg;
  endtask

  task automatic set_rand_op(input logic [TAG_W-1:0] tg);
    set_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0), $urandom, $urandom, $urandom, tg);
  endtask

  // One cycle: scoreboard the current handshakes, then step to the next falling edge.
  task automatic tick();
    logic [W-1:0] e;
    #1;
    chk("busy_vs_inflight", busy, exp_q.size() != 0);
    if (exp_q.size() == 0) chk("no_valid_when_empty", out_valid, 0);
    if (hold_pending) begin
      chk("stall_valid_stable", out_valid, 1);
      chk("stall_data_stable", out_data, hold_data);
      chk("stall_tag_stable", out_tag, hold_tag);
      hold_pending = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[XLEN-1:0]);
        chk("out_tag", out_tag, e[XLEN+TAG_W-1:XLEN]);
        chk("out_exc", out_exc, e[W-2]);
        chk("out_vxsat", out_vxsat, e[W-1]);
      end
    end else if (out_valid && !flush) begin
      chk("stall_in_ready", in_ready, 0);
      hold_pending = 1'b1;
      hold_data    = out_data;
      hold_tag     = out_tag;
    end
    if (flush) begin
      chk("flush_in_ready", in_ready, 0);
      exp_q.delete();
    end
    if (in_valid && in_ready)
      exp_q.push_back(ref_model(vs1, vs2, vs3, sew, sign_mode, high_sel, widen, macc,
                                macc_neg, smul, in_tag));
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Issue one op into an empty pipe and require its result exactly STAGES cycles later.
  task automatic directed(input string name, input logic [1:0] s, input logic [1:0] sm,
      input logic hs, input logic wd, input logic mc, input logic mn, input logic sml,
      input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3,
      input logic [31:0] want, input logic want_exc, input logic want_vx);
    out_ready = 1'b1;
    set_op(s, sm, hs, wd, mc, mn, sml, v1, v2, v3, 5'd9);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      #1 chk({name, "_early"}, out_valid, 0);
      tick();
    end
    #1;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, want);
    chk({name, "_exc"}, out_exc, want_exc);
    chk({name, "_vxsat"}, out_vxsat, want_vx);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int next, acc_ok, c;
    logic [31:0] w_sat, w_q;
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_exc", out_exc, 0);
    chk("rst_out_vxsat", out_vxsat, 0);
    chk("rst_busy", busy, 0);
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    directed("ss32_high", 2'd2, 2'd1, 1, 0, 0, 0, 0, 32'h2, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0);
    directed("ss32_low", 2'd2, 2'd1, 0, 0, 0, 0, 0, 32'h2, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 0, 0);
    directed("su8_widen", 2'd0, 2'd2, 0, 1, 0, 0, 0, 32'hFF, 32'h80, 0, 32'h00008080, 0, 0);
    directed("macc_neg16", 2'd1, 2'd0, 0, 0, 1, 1, 0, 32'h4, 32'h3, 32'd10, 32'h0000FFFE, 0, 0);
    directed("macc16", 2'd1, 2'd0, 0, 0, 1, 0, 0, 32'h4, 32'h3, 32'd10, 32'h00000016, 0, 0);
    directed("sew_illegal", 2'd3, 2'd1, 0, 0, 0, 0, 0, 32'h5, 32'h7, 0, 32'h0, 1, 0);
    directed("widen_high_illegal", 2'd0, 2'd0, 1, 1, 0, 0, 0, 32'h5, 32'h7, 0, 32'h0, 1, 0);
`ifdef VMUL_SMUL_EN
    w_sat = 32'h7F; w_q = 32'h20;
`else
    w_sat = 32'h00; w_q = 32'h00;
`endif
    directed("smul_sat", 2'd0, 2'd1, 0, 0, 0, 0, 1, 32'h80, 32'h80, 0, w_sat, 0,
`ifdef VMUL_SMUL_EN
             1);
`else
             0);
`endif
    directed("smul_q", 2'd0, 2'd1, 0, 0, 0, 0, 1, 32'h40, 32'h40, 0, w_q, 0, 0);

    // 8 back-to-back ops, out_ready low for cycles 4..6 after the first issue.
    next = 0;
    c = 0;
    while ((next < 8 || exp_q.size() != 0) && c < 40) begin
      out_ready = !(c >= 4 && c <= 6);
      if (next < 8) set_rand_op(5'(next));
      else in_valid = 1'b0;
      #1 acc_ok = int'(in_valid && in_ready);
      tick();
      next += acc_ok;
      c++;
    end
    chk("hs_all_issued", next, 8);
    chk("hs_drained", exp_q.size(), 0);
    chk("hs_busy_low", busy, 0);
    out_ready = 1'b1;

    // Flush with two ops in flight and a third offered in the flush cycle.
    set_rand_op(5'd20); tick();
    set_rand_op(5'd21); tick();
    set_rand_op(5'd22); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i <= STAGES; i++) begin
      #1 chk("flush_no_valid", out_valid, 0);
      tick();
    end
    directed("post_flush", 2'd1, 2'd1, 0, 0, 0, 0, 0, 32'h7, 32'hFFFE, 0, 32'h0000FFF2, 0, 0);

    // Randomized traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) set_rand_op(5'($urandom));
      else in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("rand_drained", exp_q.size(), 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      set_rand_op(5'(i + 1));
      sew = 2'd1; sign_mode = 2'd0; widen = 1'b0;
      tick();
    end
    nRST = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_tag", out_tag, 0);
    chk("mid_rst_out_exc", out_exc, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    hold_pending = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    directed("post_reset", 2'd0, 2'd0, 0, 0, 0, 0, 0, 32'hFF, 32'hFF, 0, 32'h01, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
